// File: rtl/cam_pkg.sv
// Shared types and constants for the camera pixel capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } cam_state_e;

  typedef enum logic {
    MODE_RGB565 = 1'b0,
    MODE_YUV_Y  = 1'b1
  } cam_mode_e;

  // Decimation must be a power of two so column/row "mod DECIM" is a mask.
  localparam int DECIM_MIN = 1;
  localparam int DECIM_MAX = 4;

  function automatic bit decim_legal(input int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
  } byte_pair_t;

endpackage

// File: rtl/cam_pix_pack.sv
// Byte pair to 12-bit pixel: RGB565 -> RGB444, or YUV422 luma -> grey444.
module cam_pix_pack
  import cam_pkg::*;
(
  input  logic        mode,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  output logic [11:0] pix
);

  // Bits dropped when truncating each colour channel.
  logic unused_bits;
  assign unused_bits = ^{b1[3], b2[6:5], b2[0]};

  // Select the conversion for the frame's latched mode.
  always_comb begin
    pix = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
    if (cam_mode_e'(mode) == MODE_YUV_Y) pix = {3{b1[7:4]}};
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// DVP camera capture: frames byte pairs from vsync/href into 12-bit BRAM writes,
// with optional decimation, line-length checking and overflow protection.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              i_pclk,
  input  logic              i_rstn_pclk,
  input  logic              i_cam_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_D,
  input  logic              i_mode,
  output logic              o_wr,
  output logic [11:0]       o_pix_data,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_line_err,
  output logic              o_ovf
);

  localparam int NPIX   = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);
  localparam int BCNT_W = $clog2(2 * H_ACTIVE + 1) + 1;
  localparam int COL_W  = $clog2(H_ACTIVE + 1) + 1;
  localparam int ROW_W  = $clog2(V_ACTIVE + 1) + 1;
  localparam int STAGES = 1;

  // Address carries one spare bit so the end-of-frame value is representable
  // even when NPIX is an exact power of two.
  localparam logic [ADDR_W:0]   ADDR_END   = (ADDR_W + 1)'(NPIX);
  localparam logic [BCNT_W-1:0] LINE_BYTES = BCNT_W'(2 * H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_MASK   = COL_W'(DECIM - 1);
  localparam logic [ROW_W-1:0]  ROW_MASK   = ROW_W'(DECIM - 1);

  if (!decim_legal(DECIM)) begin : g_bad_decim
    $error("cam_pixel_capture: DECIM must be 1, 2 or 4");
  end
  if (ADDR_W < $clog2(NPIX)) begin : g_bad_addr_w
    $error("cam_pixel_capture: ADDR_W too small for the decimated frame");
  end

  cam_state_e        state_q, state_d;
  logic              vs_r, hr_r, vs_q, hr_q;
  logic [7:0]        d_r, b1_q;
  logic              enter_act, frame_end, act;
  logic              phase_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  cam_mode_e         mode_q;
  logic [STAGES:0]   vld_pipe;
  logic [11:0]       pack_pix, pix_q;
  logic [ADDR_W:0]   addr_q;
  logic              pix_ok;
  byte_pair_t        pair;

  wire vs_fall = vs_q & ~vs_r;
  wire vs_rise = vs_r & ~vs_q;

  assign act        = (state_q == ST_ACTIVE) && i_cam_done;
  assign pair       = {b1_q, d_r};
  assign pix_ok     = act && hr_r && phase_q &&
                      ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
  assign o_wr       = vld_pipe[STAGES];
  assign o_pix_addr = addr_q[ADDR_W-1:0];

  cam_pix_pack u_pack (
    .mode (mode_q),
    .b1   (pair.b1),
    .b2   (pair.b2),
    .pix  (pack_pix)
  );

  // Input stage plus one extra delay for sync edge detection.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      vs_r <= 1'b0; hr_r <= 1'b0; d_r <= 8'h00;
      vs_q <= 1'b0; hr_q <= 1'b0;
    end else begin
      vs_r <= i_vsync; hr_r <= i_href; d_r <= i_D;
      vs_q <= vs_r;    hr_q <= hr_r;
    end
  end

  // Capture state register.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state; losing cam_done abandons everything, including a frame end.
  always_comb begin
    state_d   = state_q;
    enter_act = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE:       if (i_cam_done) state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (vs_fall) begin state_d = ST_ACTIVE; enter_act = 1'b1; end
      ST_ACTIVE:     if (vs_rise) begin state_d = ST_WAIT_FRAME; frame_end = 1'b1; end
      default:       state_d = ST_IDLE;
    endcase
    if (!i_cam_done) begin
      state_d   = ST_IDLE;
      enter_act = 1'b0;
      frame_end = 1'b0;
    end
  end

  // Byte phase, column/row tracking and line-length checking. Line end is
  // processed even on the edge that closes the frame.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      phase_q    <= 1'b0;
      bcnt_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      b1_q       <= 8'h00;
      mode_q     <= MODE_RGB565;
      o_line_err <= 1'b0;
    end else if (enter_act) begin
      phase_q    <= 1'b0;
      bcnt_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= cam_mode_e'(i_mode);
      o_line_err <= 1'b0;
    end else if (act) begin
      if (hr_r) begin
        phase_q <= ~phase_q;
        if (bcnt_q != '1) bcnt_q <= bcnt_q + BCNT_W'(1);
        if (!phase_q) b1_q  <= d_r;
        else          col_q <= col_q + COL_W'(1);
      end else begin
        phase_q <= 1'b0;
        if (hr_q) begin
          row_q  <= row_q + ROW_W'(1);
          col_q  <= '0;
          bcnt_q <= '0;
          if (bcnt_q != LINE_BYTES || phase_q) o_line_err <= 1'b1;
        end
      end
    end
  end

  // Write pipeline: pixel stage, then the write strobe gated by frame capacity.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      vld_pipe   <= '0;
      pix_q      <= 12'h000;
      o_pix_data <= 12'h000;
      addr_q     <= '0;
      o_ovf      <= 1'b0;
    end else begin
      vld_pipe[0]      <= pix_ok;
      vld_pipe[STAGES] <= vld_pipe[0] && (addr_q != ADDR_END) && i_cam_done;
      if (pix_ok)      pix_q      <= pack_pix;
      if (vld_pipe[0]) o_pix_data <= pix_q;
      if (enter_act) begin
        addr_q <= '0;
        o_ovf  <= 1'b0;
      end else begin
        if (o_wr) addr_q <= addr_q + (ADDR_W + 1)'(1);
        if (vld_pipe[0] && addr_q == ADDR_END) o_ovf <= 1'b1;
      end
    end
  end

  // End-of-frame pulse and completed-frame counter.
  always_ff @(posedge i_pclk or negedge i_rstn_pclk) begin
    if (!i_rstn_pclk) begin
      o_frame_done <= 1'b0;
      o_frame_cnt  <= 8'd0;
    end else begin
      o_frame_done <= frame_end;
      if (frame_end) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture: two configurations, a frame-level model that
// predicts every write, and directed frames with literal expectations.
module tb_cam_pixel_capture;

  localparam int HA = 4, VA = 2, DA = 1;
  localparam int HB = 8, VB = 4, DB = 2;
  localparam int AW = 4;

  logic clk = 1'b0, rst_n = 1'b0, cam_done = 1'b0, mode = 1'b0;
  logic vs = 1'b1, hr = 1'b0, tgt = 1'b0;
  logic [7:0] d = 8'h00;

  always #5 clk = ~clk;

  // Only the targeted instance sees live sync; the other sits in blanking.
  wire vs_a = tgt ? 1'b1 : vs;
  wire hr_a = tgt ? 1'b0 : hr;
  wire vs_b = tgt ? vs : 1'b1;
  wire hr_b = tgt ? hr : 1'b0;

  logic          wr_a, fd_a, err_a, ovf_a, wr_b, fd_b, err_b, ovf_b;
  logic [11:0]   data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [7:0]    fc_a, fc_b;

  cam_pixel_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DECIM(DA), .ADDR_W(AW)) dut_a (
    .i_pclk(clk), .i_rstn_pclk(rst_n), .i_cam_done(cam_done), .i_vsync(vs_a),
    .i_href(hr_a), .i_D(d), .i_mode(mode), .o_wr(wr_a), .o_pix_data(data_a),
    .o_pix_addr(addr_a), .o_frame_done(fd_a), .o_frame_cnt(fc_a),
    .o_line_err(err_a), .o_ovf(ovf_a));

  cam_pixel_capture #(.H_ACTIVE(HB), .V_ACTIVE(VB), .DECIM(DB), .ADDR_W(AW)) dut_b (
    .i_pclk(clk), .i_rstn_pclk(rst_n), .i_cam_done(cam_done), .i_vsync(vs_b),
    .i_href(hr_b), .i_D(d), .i_mode(mode), .o_wr(wr_b), .o_pix_data(data_b),
    .o_pix_addr(addr_b), .o_frame_done(fd_b), .o_frame_cnt(fc_b),
    .o_line_err(err_b), .o_ovf(ovf_b));

  typedef struct { int addr; logic [11:0] data; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  int tests = 0, fails = 0, cyc = 0;
  int fd_seen_a = 0, fd_seen_b = 0, wr_cnt_b = 0;
  int lat_drive = -1, lat_wr = -1;
  logic lat_arm = 1'b0, fd_prev_a = 1'b0, fd_prev_b = 1'b0;
  logic [11:0] last_data_a = 12'h000;

  // Frame-level model state.
  int m_wcnt, m_H, m_D, m_npix;
  logic m_ovf, m_err, m_mode;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pixel value from the conversion rules, computed arithmetically.
  function automatic logic [11:0] model_pix(input logic md, input logic [7:0] b1, input logic [7:0] b2);
    int r;
    if (md) r = (int'(b1) / 16) * 'h111;
    else    r = (int'(b1) / 16) * 256 + (int'(b1) % 8) * 32 + (int'(b2) / 128) * 16 + (int'(b2) / 2) % 16;
    return 12'(r);
  endfunction

  // Compare process: every write is checked against the model's queue.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (wr_a) begin
        last_data_a = data_a;
        if (lat_arm && lat_wr < 0) lat_wr = cyc;
        chk("A write expected", 64'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("A wr addr", 64'(addr_a), 64'(ea.addr));
          chk("A wr data", 64'(data_a), 64'(ea.data));
        end
      end
      if (wr_b) begin
        wr_cnt_b++;
        chk("B write expected", 64'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("B wr addr", 64'(addr_b), 64'(eb.addr));
          chk("B wr data", 64'(data_b), 64'(eb.data));
        end
      end
      if (fd_a) begin fd_seen_a++; chk("A frame_done one cycle", 64'(fd_prev_a), 0); end
      if (fd_b) begin fd_seen_b++; chk("B frame_done one cycle", 64'(fd_prev_b), 0); end
    end
    fd_prev_a = fd_a;
    fd_prev_b = fd_b;
  end

  task automatic drive(input logic h, input logic v, input logic [7:0] b);
    @(posedge clk); #1;
    hr = h; vs = v; d = b;
  endtask

  task automatic frame_begin(input logic t, input logic md);
    tgt = t; mode = md; m_mode = md;
    m_wcnt = 0; m_ovf = 1'b0; m_err = 1'b0;
    m_H = t ? HB : HA; m_D = t ? DB : DA;
    m_npix = (m_H / m_D) * ((t ? VB : VA) / m_D);
    repeat (4) drive(1'b0, 1'b1, 8'h00);
    repeat (5) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int r, input int len, input logic [7:0] b1, input logic [7:0] b2,
                           input int step, input bit conc);
    logic [7:0] x, y;
    int p;
    for (int k = 0; k < len; k++) begin
      p = k / 2;
      x = b1 + 8'(step * (r * 16 + p));
      y = b2 + 8'(step * (r + p));
      drive(1'b1, 1'b0, (k % 2 == 0) ? x : y);
      if (k % 2 == 1) begin
        if (lat_arm && lat_drive < 0) lat_drive = cyc;
        if (r % m_D == 0 && p % m_D == 0) begin
          if (m_wcnt < m_npix) begin
            if (tgt) qb.push_back('{addr: m_wcnt, data: model_pix(m_mode, x, y)});
            else     qa.push_back('{addr: m_wcnt, data: model_pix(m_mode, x, y)});
            m_wcnt++;
          end else m_ovf = 1'b1;
        end
      end
    end
    if (len != 2 * m_H || len % 2 != 0) m_err = 1'b1;
    if (conc) drive(1'b0, 1'b1, 8'h00);
    else repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_finish(input bit conc);
    if (!conc) drive(1'b0, 1'b1, 8'h00);
    repeat (6) drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic send_frame(input string tag, input logic t, input logic md, input int nl,
                            input int len, input int short_idx, input int short_len,
                            input logic [7:0] b1, input logic [7:0] b2, input int step,
                            input bit conc_last, input bit flip, input int exp_cnt);
    int fd0;
    frame_begin(t, md);
    fd0 = t ? fd_seen_b : fd_seen_a;
    chk({tag, " err clear at start"}, 64'(t ? err_b : err_a), 0);
    chk({tag, " ovf clear at start"}, 64'(t ? ovf_b : ovf_a), 0);
    for (int r = 0; r < nl; r++) begin
      send_line(r, (r == short_idx) ? short_len : len, b1, b2, step, conc_last && (r == nl - 1));
      if (flip && r == 0) mode = ~mode;
    end
    frame_finish(conc_last);
    chk({tag, " writes drained"}, 64'(t ? qb.size() : qa.size()), 0);
    chk({tag, " frame_done pulses"}, 64'((t ? fd_seen_b : fd_seen_a) - fd0), 1);
    chk({tag, " frame_cnt"}, 64'(t ? fc_b : fc_a), 64'(exp_cnt));
    chk({tag, " line_err"}, 64'(t ? err_b : err_a), 64'(m_err));
    chk({tag, " ovf"}, 64'(t ? ovf_b : ovf_a), 64'(m_ovf));
    chk({tag, " final addr"}, 64'(t ? addr_b : addr_a), 64'(m_wcnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs A", {wr_a, fd_a, err_a, ovf_a, data_a, 4'(addr_a), fc_a}, 0);
    rst_n = 1'b1; cam_done = 1'b1;

    // RGB565 F8/1F everywhere -> eight F0F writes, with the write latency pinned.
    lat_arm = 1'b1;
    send_frame("F1", 1'b0, 1'b0, 2, 8, -1, 0, 8'hF8, 8'h1F, 0, 1'b0, 1'b0, 1);
    lat_arm = 1'b0;
    chk("F1 pixel literal", 64'(last_data_a), 64'h0F0F);
    chk("F1 write latency", 64'(lat_wr - lat_drive), 3);
    chk("F1 addr literal", 64'(addr_a), 8);

    // 7-byte first line.
    send_frame("F2", 1'b0, 1'b0, 2, 8, 0, 7, 8'h12, 8'h9C, 1, 1'b0, 1'b0, 2);
    chk("F2 line_err literal", 64'(err_a), 1);

    // Clean frame after an error frame.
    send_frame("F3", 1'b0, 1'b0, 2, 8, -1, 0, 8'h3B, 8'hE6, 3, 1'b0, 1'b0, 3);

    // Three lines beyond the frame.
    send_frame("F4", 1'b0, 1'b0, 5, 8, -1, 0, 8'h55, 8'hAA, 5, 1'b0, 1'b0, 4);
    chk("F4 ovf literal", 64'(ovf_a), 1);
    chk("F4 addr held literal", 64'(addr_a), 8);

    // Luma mode, with i_mode flipped mid-frame.
    send_frame("F5", 1'b0, 1'b1, 2, 8, -1, 0, 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 5);
    chk("F5 grey literal", 64'(last_data_a), 64'h0AAA);

    // Short last line ending on the same edge as vsync rising.
    send_frame("F6", 1'b0, 1'b0, 2, 8, 1, 5, 8'h70, 8'h0F, 2, 1'b1, 1'b0, 6);
    chk("F6 line_err literal", 64'(err_a), 1);

    // Reset in the middle of a line.
    frame_begin(1'b0, 1'b0);
    send_line(0, 8, 8'hC3, 8'h5A, 1, 1'b0);
    chk("pre-reset addr", 64'(addr_a), 4);
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b0, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs A", {wr_a, fd_a, err_a, ovf_a, data_a, 4'(addr_a), fc_a}, 0);
    qa.delete();
    repeat (3) drive(1'b0, 1'b1, 8'h00);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b1, 8'h00);
    chk("post-reset frame_cnt", 64'(fc_a), 0);

    // cam_done drops mid-frame.
    frame_begin(1'b0, 1'b0);
    fd0 = fd_seen_a;
    send_line(0, 8, 8'h81, 8'h42, 1, 1'b0);
    cam_done = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    cam_done = 1'b1;
    frame_finish(1'b0);
    chk("abandon frame_done", 64'(fd_seen_a - fd0), 0);
    chk("abandon frame_cnt", 64'(fc_a), 0);
    chk("abandon writes drained", 64'(qa.size()), 0);

    send_frame("F9", 1'b0, 1'b0, 2, 8, -1, 0, 8'h1E, 8'hD2, 7, 1'b0, 1'b0, 1);

    // Decimation by 2 on the 8x4 instance.
    send_frame("F10", 1'b1, 1'b0, 4, 16, -1, 0, 8'h10, 8'h20, 1, 1'b0, 1'b0, 1);
    chk("F10 write count literal", 64'(wr_cnt_b), 8);
    chk("F10 addr literal", 64'(addr_b), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
